// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared types and defaults for the bit-serial adder
//                controller. It holds the controller state enum and the
//                default operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_ctrl_if
//  Description : Request and result handshake bundle for serial_adder_ctrl.
//                master = requester/consumer side, slave = adder controller.
//                Request : start_valid, start_ready, a, b, cin
//                Result  : result_valid, result_ready, sum, cout
//                Status  : busy
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_ctrl_if #(
    parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output start_valid, a, b, cin, result_ready,
        input  start_ready, result_valid, sum, cout, busy
    );

    modport slave (
        input  start_valid, a, b, cin, result_ready,
        output start_ready, result_valid, sum, cout, busy
    );
endinterface
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : One-bit full adder cell.
//                Inputs  : a, b, cin
//                Outputs : sum, cout
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    output logic      sum,
    output logic      cout
);
    logic w_p;

    assign w_p  = a ^ b;
    assign sum  = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);
endmodule
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_ctrl
//  Description : Bit-serial adder controller. One full_adder cell is reused
//                for every bit of the operand pair, LSB first, one bit per
//                clock. Operands are taken on a valid/ready handshake, and the
//                sum is offered on a second valid/ready handshake.
//                clk   : rising-edge clock
//                rst_n : synchronous reset, active low
//                bus   : serial_adder_ctrl_if.slave (request/result/busy)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    serial_adder_ctrl_if.slave    bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic             w_last;

    full_adder u_full_adder (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .cin  (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    // Final bit is being consumed on this edge.
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start_valid)  w_state_next = RUN;
            RUN:     if (w_last)           w_state_next = DONE;
            DONE:    if (bus.result_ready) w_state_next = IDLE;
            default:                       w_state_next = IDLE;
        endcase
    end

    // The sum register is not cleared on accept: WIDTH shifts overwrite it
    // completely before DONE exposes it through result_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start_valid) begin
                        r_sa    <= bus.a;
                        r_sb    <= bus.b;
                        r_carry <= bus.cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_sa    <= r_sa >> 1;
                    r_sb    <= r_sb >> 1;
                    r_sum   <= (r_sum >> 1) | (WIDTH'(w_fa_sum) << (WIDTH - 1));
                    r_carry <= w_fa_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_cout <= w_fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs depend on state only, so neither valid input reaches
    // an output combinationally.
    assign bus.start_ready  = (r_state == IDLE);
    assign bus.result_valid = (r_state == DONE);
    assign bus.busy         = (r_state == RUN) || (r_state == DONE);
    assign bus.sum          = r_sum;
    assign bus.cout         = r_cout;
endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder_ctrl
//  Description : Self-checking bench for serial_adder_ctrl. Drives a WIDTH=8
//                and a WIDTH=1 instance; expected sums come from a+b+cin.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8)) if8 ();
    serial_adder_ctrl_if #(.WIDTH(1)) if1 ();

    serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       c;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One complete transaction on the 8-bit instance, with latency,
    // backpressure-stability and release checks along the way.
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input int pre, input int hold, input bit noise,
                          output logic [7:0] s, output logic c);
        int n;
        bit ready_in_run;
        if8.start_valid  = 1'b0;
        if8.result_ready = 1'b0;
        repeat (pre) tick();
        n = 0;
        while (!if8.start_ready && n < 50) begin
            tick();
            n++;
        end
        check("ready_before_accept", 32'(if8.start_ready), 32'd1);
        if8.a = a; if8.b = b; if8.cin = cin; if8.start_valid = 1'b1;
        tick();
        if8.start_valid = 1'b0;
        n = 0;
        ready_in_run = 1'b0;
        while (!if8.result_valid && n < 50) begin
            if (if8.start_ready || !if8.busy) ready_in_run = 1'b1;
            if (noise) begin
                if8.start_valid  = 1'($urandom_range(0, 1));
                if8.a            = 8'($urandom);
                if8.b            = 8'($urandom);
                if8.cin          = 1'($urandom);
                if8.result_ready = 1'($urandom_range(0, 1));
            end
            tick();
            n++;
        end
        if8.start_valid  = 1'b0;
        if8.result_ready = 1'b0;
        check("latency", 32'(n), 32'd8);
        check("run_ready_low_busy_high", 32'(ready_in_run), 32'd0);
        s = if8.sum;
        c = if8.cout;
        check("done_busy", 32'(if8.busy), 32'd1);
        repeat (hold) begin
            tick();
            check("hold_sum", 32'(if8.sum), 32'(s));
            check("hold_cout", 32'(if8.cout), 32'(c));
            check("hold_valid", 32'(if8.result_valid), 32'd1);
            check("hold_start_ready", 32'(if8.start_ready), 32'd0);
        end
        if8.result_ready = 1'b1;
        tick();
        if8.result_ready = 1'b0;
        check("taken_valid", 32'(if8.result_valid), 32'd0);
        check("taken_start_ready", 32'(if8.start_ready), 32'd1);
        check("taken_busy", 32'(if8.busy), 32'd0);
    endtask

    task automatic do_op1(input logic a, input logic b, input logic cin,
                          output logic s, output logic c);
        int n;
        if1.a = a; if1.b = b; if1.cin = cin; if1.start_valid = 1'b1;
        tick();
        if1.start_valid = 1'b0;
        n = 0;
        while (!if1.result_valid && n < 10) begin
            tick();
            n++;
        end
        check("w1_latency", 32'(n), 32'd1);
        s = if1.sum;
        c = if1.cout;
        if1.result_ready = 1'b1;
        tick();
        if1.result_ready = 1'b0;
        check("w1_taken_ready", 32'(if1.start_ready), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl [7];
        logic [7:0] s;
        logic       c;
        logic [8:0] model;
        logic       s1, c1;
        logic [1:0] m1;

        tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        tbl[4] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
        tbl[5] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        tbl[6] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};

        if8.start_valid = 1'b0; if8.result_ready = 1'b0;
        if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        if1.start_valid = 1'b0; if1.result_ready = 1'b0;
        if1.a = '0; if1.b = '0; if1.cin = 1'b0;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_sum", 32'(if8.sum), 32'd0);
        check("rst_cout", 32'(if8.cout), 32'd0);
        check("rst_valid", 32'(if8.result_valid), 32'd0);
        check("rst_busy", 32'(if8.busy), 32'd0);
        check("rst_start_ready", 32'(if8.start_ready), 32'd1);
        check("rst_w1_valid", 32'(if1.result_valid), 32'd0);
        check("rst_w1_start_ready", 32'(if1.start_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Directed vector table
        foreach (tbl[i]) begin
            do_op8(tbl[i].a, tbl[i].b, tbl[i].cin, 0, 0, 1'b0, s, c);
            check($sformatf("tbl%0d_sum", i), 32'(s), 32'(tbl[i].s));
            check($sformatf("tbl%0d_cout", i), 32'(c), 32'(tbl[i].c));
        end

        // Backpressure: five held cycles in DONE
        do_op8(8'h0F, 8'h01, 1'b0, 1, 5, 1'b0, s, c);
        check("bp_sum", 32'(s), 32'h10);
        check("bp_cout", 32'(c), 32'd0);

        // New operands pulsed during RUN are ignored
        if8.a = 8'h12; if8.b = 8'h34; if8.cin = 1'b0; if8.start_valid = 1'b1;
        tick();
        if8.start_valid = 1'b0;
        tick(); tick();
        if8.a = 8'hFF; if8.b = 8'hFF; if8.cin = 1'b1; if8.start_valid = 1'b1;
        tick();
        if8.start_valid = 1'b0;
        begin
            int n = 0;
            while (!if8.result_valid && n < 20) begin tick(); n++; end
            check("ignore_latency", 32'(n), 32'd5);
        end
        check("ignore_sum", 32'(if8.sum), 32'h46);
        check("ignore_cout", 32'(if8.cout), 32'd0);
        if8.result_ready = 1'b1;
        tick();
        if8.result_ready = 1'b0;
        check("ignore_taken", 32'(if8.start_ready), 32'd1);

        // Reset while bit 3 is about to be consumed
        if8.a = 8'hFF; if8.b = 8'h01; if8.cin = 1'b1; if8.start_valid = 1'b1;
        tick();
        if8.start_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        check("abort_sum", 32'(if8.sum), 32'd0);
        check("abort_cout", 32'(if8.cout), 32'd0);
        check("abort_valid", 32'(if8.result_valid), 32'd0);
        check("abort_busy", 32'(if8.busy), 32'd0);
        check("abort_start_ready", 32'(if8.start_ready), 32'd1);
        rst_n = 1'b1;
        do_op8(8'h3C, 8'h0F, 1'b1, 0, 0, 1'b0, s, c);
        check("after_abort_sum", 32'(s), 32'h4C);
        check("after_abort_cout", 32'(c), 32'd0);

        // WIDTH=1 instance: every input combination
        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = 3'(k);
            do_op1(v[2], v[1], v[0], s1, c1);
            m1 = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
            check($sformatf("w1_sum_%0d", k), 32'(s1), 32'(m1[0]));
            check($sformatf("w1_cout_%0d", k), 32'(c1), 32'(m1[1]));
        end

        // Random soak against a+b+cin
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            logic       rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            model = 9'(ra) + 9'(rb) + 9'(rc);
            do_op8(ra, rb, rc, $urandom_range(0, 2), $urandom_range(0, 3), 1'b1, s, c);
            check("soak_sum", 32'(s), 32'(model[7:0]));
            check("soak_cout", 32'(c), 32'(model[8]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
